// File: rtl/counter_timer_ctrl_if.sv
// Host control/status and Counter pin bundle for counter_timer_ctrl.
// The master side is the host plus the Counter; the slave side is the sequencer.
interface counter_timer_ctrl_if #(
   parameter int WIDTH = 4
);
   logic             cfg_we;
   logic [WIDTH-1:0] cfg_divisor;
   logic             cfg_periodic;
   logic             start;
   logic             stop;
   logic             irq_ack;
   logic             cnt_reset_n;
   logic             cnt_load_n;
   logic             cnt_count;
   logic [WIDTH-1:0] cnt_d;
   logic             cnt_carry_n;
   logic             tick;
   logic             irq;
   logic             overrun;
   logic             busy;

   modport master (
      output cfg_we, cfg_divisor, cfg_periodic, start, stop, irq_ack, cnt_carry_n,
      input  cnt_reset_n, cnt_load_n, cnt_count, cnt_d, tick, irq, overrun, busy
   );

   modport slave (
      input  cfg_we, cfg_divisor, cfg_periodic, start, stop, irq_ack, cnt_carry_n,
      output cnt_reset_n, cnt_load_n, cnt_count, cnt_d, tick, irq, overrun, busy
   );
endinterface

// File: rtl/counter_timer_ctrl.sv
// Sequencer that drives an external up-Counter as a prescaled periodic or one-shot
// interval timer, with an irq/ack handshake and a sticky overrun flag.
module counter_timer_ctrl #(
   parameter int WIDTH   = 4,
   parameter int PRE_DIV = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   counter_timer_ctrl_if.slave  bus
);
   localparam int            PW       = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(PRE_DIV - 1);

   typedef enum logic [1:0] {CLEAR, IDLE, LOAD, RUN} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] div_q, div_d;
   logic             periodic_q, periodic_d;
   logic [PW-1:0]    pre_q, pre_d;
   logic             irq_q, irq_d;
   logic             ovr_q, ovr_d;

   logic go;
   logic en;
   logic tick;

   assign go = bus.start & ~bus.stop;
   assign en = (state_q == RUN) && (pre_q == PRE_LAST);
   // Expiry loses to both stop and a restart request in the same cycle.
   assign tick = en & ~bus.cnt_carry_n & ~bus.stop & ~bus.start;

   always_comb begin
      state_d    = state_q;
      pre_d      = pre_q;
      div_d      = bus.cfg_we ? bus.cfg_divisor  : div_q;
      periodic_d = bus.cfg_we ? bus.cfg_periodic : periodic_q;
      unique case (state_q)
         CLEAR: state_d = go ? LOAD : IDLE;
         IDLE: begin
            if (go) state_d = LOAD;
         end
         LOAD: begin
            pre_d   = '0;
            state_d = bus.stop ? CLEAR : RUN;
         end
         RUN: begin
            pre_d = en ? '0 : pre_q + PW'(1);
            if (bus.stop)                   state_d = CLEAR;
            else if (bus.start)             state_d = LOAD;
            else if (tick && !periodic_q)   state_d = IDLE;
         end
         default: state_d = CLEAR;
      endcase
      irq_d = tick | (irq_q & ~bus.irq_ack);
      ovr_d = ~bus.irq_ack & (ovr_q | (tick & irq_q));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= CLEAR;
         div_q      <= '0;
         periodic_q <= 1'b0;
         pre_q      <= '0;
         irq_q      <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         periodic_q <= periodic_d;
         pre_q      <= pre_d;
         irq_q      <= irq_d;
         ovr_q      <= ovr_d;
      end
   end

   // Periodic expiry reloads over the count; one-shot expiry suppresses the count
   // so the Counter parks at all-ones.
   assign bus.cnt_reset_n = (state_q != CLEAR);
   assign bus.cnt_load_n  = ~((state_q == LOAD) | (tick & periodic_q));
   assign bus.cnt_count   = en & ~(tick & ~periodic_q);
   assign bus.cnt_d       = ~div_q + WIDTH'(1);
   assign bus.tick        = tick;
   assign bus.irq         = irq_q;
   assign bus.overrun     = ovr_q;
   assign bus.busy        = (state_q == LOAD) || (state_q == RUN);
endmodule
